// File: rtl/exp_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// exp_pkg
// Shared widths and FSM state type for the exponential-core arbiter.
//   X_W    : operand width sent to the core
//   RES_W  : result width {2-bit integer, FRAC_W-bit fraction}
//   FRAC_W : fractional bits of the result
//   state_t: arbiter FSM states
// -----------------------------------------------------------------------------
package exp_pkg;
  localparam int X_W    = 16;
  localparam int RES_W  = 18;
  localparam int FRAC_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/exp_arbiter_if.sv
// -----------------------------------------------------------------------------
// exp_arbiter_if
// Bundles the requester-side and core-side signals of the arbiter.
//   req/x_in             : per-requester request level and operand
//   ack/result/err       : completion pulse, shared result, timeout flag
//   busy/grant_id        : arbiter activity and current/most recent grantee
//   core_start/core_x    : start strobe and operand to the exponential core
//   core_done/core_result: completion flag and result from the core
// Modports: slave = arbiter view, master = environment (requesters + core).
// -----------------------------------------------------------------------------
interface exp_arbiter_if #(
  parameter int N_REQ = 4
) ();
  import exp_pkg::*;

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]     req;
  logic [N_REQ*X_W-1:0] x_in;
  logic [N_REQ-1:0]     ack;
  logic [RES_W-1:0]     result;
  logic                 err;
  logic                 busy;
  logic [ID_W-1:0]      grant_id;
  logic                 core_start;
  logic [X_W-1:0]       core_x;
  logic                 core_done;
  logic [RES_W-1:0]     core_result;

  modport slave (
    input  req, x_in, core_done, core_result,
    output ack, result, err, busy, grant_id, core_start, core_x
  );

  modport master (
    output req, x_in, core_done, core_result,
    input  ack, result, err, busy, grant_id, core_start, core_x
  );
endinterface

// File: rtl/exp_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin selector.
//   req        : request vector
//   last_grant : most recently served requester
//   found      : at least one request is set
//   idx        : first set request searching upward from last_grant+1 (wrapping)
// Each requester's distance from last_grant+1 is computed in parallel and the
// nearest set request wins, which avoids a variable-index rotate.
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic             found,
  output logic [ID_W-1:0]  idx
);
  int dist_w [N_REQ];
  int best;

  // Distance 0 is the requester right after last_grant; last_grant itself is N_REQ-1.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dist
    assign dist_w[gi] = (gi + 2 * N_REQ - 1 - int'(last_grant)) % N_REQ;
  end

  always_comb begin
    found = 1'b0;
    idx   = '0;
    best  = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && (dist_w[i] < best)) begin
        best  = dist_w[i];
        idx   = ID_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/exp_arbiter.sv
// -----------------------------------------------------------------------------
// exp_arbiter
// Shares one exponential (cosh) core among N_REQ requesters.
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : exp_arbiter_if.slave (requester and core signals)
// Flow: IDLE picks a requester round-robin and latches its operand, START
// pulses core_start, WAIT waits for core_done (bounded by TIMEOUT cycles),
// RESP pulses ack for one cycle with the result or an error.
// core_done/core_result are registered once before WAIT acts on them, so an
// ack appears two cycles after done is sampled. Only done seen while in WAIT
// is registered, which drops any stale done left over from an earlier op.
// -----------------------------------------------------------------------------
module exp_arbiter
  import exp_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  exp_arbiter_if.slave  bus
);
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [ID_W-1:0]  grant_reg, grant_next;
  logic [ID_W-1:0]  last_reg, last_next;
  logic [X_W-1:0]   x_reg, x_next;
  logic [RES_W-1:0] res_reg, res_next;
  logic             err_reg, err_next;
  logic             done_q_reg;
  logic [RES_W-1:0] core_res_q_reg;

  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic [X_W-1:0]   x_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign x_arr[gi] = bus.x_in[gi*X_W +: X_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req        (bus.req),
    .last_grant (last_reg),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  // Next-state and datapath updates
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    x_next     = x_reg;
    res_next   = res_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          grant_next = pick_idx;
          x_next     = x_arr[pick_idx];
          state_next = ST_START;
        end
      end
      ST_START: begin
        cnt_next   = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_q_reg) begin
          res_next   = core_res_q_reg;
          err_next   = 1'b0;
          last_next  = grant_reg;
          state_next = ST_RESP;
        end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
          res_next   = '0;
          err_next   = 1'b1;
          last_next  = grant_reg;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      grant_reg <= '0;
      last_reg  <= ID_W'(N_REQ - 1);
      x_reg     <= '0;
      res_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      x_reg     <= x_next;
      res_reg   <= res_next;
      err_reg   <= err_next;
    end
  end

  // Input capture of the core handshake, qualified by WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q_reg     <= 1'b0;
      core_res_q_reg <= '0;
    end else begin
      done_q_reg <= (state_reg == ST_WAIT) && bus.core_done;
      if ((state_reg == ST_WAIT) && bus.core_done) begin
        core_res_q_reg <= bus.core_result;
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
    assign bus.ack[gi] = (state_reg == ST_RESP) && (grant_reg == ID_W'(gi));
  end

  assign bus.result     = (state_reg == ST_RESP) ? res_reg : '0;
  assign bus.err        = (state_reg == ST_RESP) && err_reg;
  assign bus.busy       = (state_reg != ST_IDLE);
  assign bus.grant_id   = grant_reg;
  assign bus.core_start = (state_reg == ST_START);
  assign bus.core_x     = x_reg;
endmodule

// File: tb/tb_exp_arbiter.sv
module tb_exp_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  exp_arbiter_if #(.N_REQ(N)) bus ();

  exp_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, exp, $time);
    end
  endfunction

  // Behavioural model: one operation in flight, tracked by its age in cycles
  // since the start strobe, plus a pending-done flag and a response flag.
  bit          m_busy, m_resp, m_pend, m_err;
  int          m_cyc, m_gnt, m_last, m_pick;
  logic [15:0] m_x;
  logic [17:0] m_res, m_pres;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_resp = 0; m_pend = 0; m_err = 0;
      m_cyc = 0; m_gnt = 0; m_last = N - 1;
      m_x = '0; m_res = '0; m_pres = '0;
    end else if (m_resp) begin
      m_resp = 0;
      m_busy = 0;
    end else if (m_busy) begin
      if (m_pend) begin
        m_resp = 1; m_res = m_pres; m_err = 0; m_last = m_gnt; m_pend = 0;
      end else if (m_cyc >= 1 && m_cyc <= TO && bus.core_done) begin
        m_pend = 1; m_pres = bus.core_result; m_cyc++;
      end else if (m_cyc == TO + 1) begin
        m_resp = 1; m_res = '0; m_err = 1; m_last = m_gnt;
      end else begin
        m_cyc++;
      end
    end else begin
      m_pick = -1;
      for (int k = 1; k <= N; k++) begin
        if (m_pick < 0 && (((bus.req >> ((m_last + k) % N)) & 4'b1) != 4'b0))
          m_pick = (m_last + k) % N;
      end
      if (m_pick >= 0) begin
        m_gnt = m_pick;
        m_x = 16'(bus.x_in >> (16 * m_pick));
        m_busy = 1; m_cyc = 0; m_pend = 0;
      end
    end
  end

  logic [3:0] e_ack;
  always @(negedge clk) begin
    e_ack = m_resp ? 4'(4'b1 << m_gnt) : 4'b0;
    chk("ack", 32'(bus.ack), 32'(e_ack));
    chk("result", 32'(bus.result), m_resp ? 32'(m_res) : 32'd0);
    chk("err", 32'(bus.err), (m_resp && m_err) ? 32'd1 : 32'd0);
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("core_start", 32'(bus.core_start), (m_busy && !m_resp && m_cyc == 0 && !m_pend) ? 32'd1 : 32'd0);
    chk("grant_id", 32'(bus.grant_id), 32'(m_gnt));
    chk("core_x", 32'(bus.core_x), 32'(m_x));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input int lat, input logic [17:0] res, input bit stale, input bit clr,
                        input bit chg, output int dly, output logic [3:0] a,
                        output logic [17:0] r, output logic e);
    int n;
    int st;
    dly = 0; a = '0; r = '0; e = 1'b0;
    n = 0;
    while (bus.core_start !== 1'b1 && n < 20) begin tick(); n++; end
    chk("start_seen", 32'(bus.core_start), 32'd1);
    st = cyc_n;
    if (stale) begin bus.core_done = 1'b1; bus.core_result = 18'h3FFFF; end
    if (lat == 0) begin tick(); bus.core_done = 1'b0; end
    for (int j = 1; j <= lat; j++) begin
      tick();
      if (j == 1 && chg) begin bus.req = '0; bus.x_in[15:0] = 16'hFFFF; end
      bus.core_done = (j == lat);
      if (j == lat) bus.core_result = res;
    end
    if (lat > 0) begin tick(); bus.core_done = 1'b0; end
    n = 0;
    while (bus.ack == '0 && n < 40) begin tick(); n++; end
    chk("ack_seen", 32'(bus.ack != '0), 32'd1);
    dly = cyc_n - st; a = bus.ack; r = bus.result; e = bus.err;
    if (clr) bus.req = '0;
    $display("op: ack=%b result=%h err=%0b start_to_ack=%0d", a, r, e, dly);
  endtask

  int          dly, gid;
  logic [3:0]  a;
  logic [17:0] r;
  logic        e;
  int          exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b0;
    bus.req = '0; bus.x_in = '0; bus.core_done = 1'b0; bus.core_result = '0;
    repeat (3) tick();
    chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_core_x", 32'(bus.core_x), 32'd0);
    rst = 1'b1;
    tick();

    // Single request
    bus.x_in[15:0] = 16'h8000; bus.req = 4'b0001;
    run_op(5, 18'h18B07, 0, 1, 0, dly, a, r, e);
    chk("t1_lat", 32'(dly), 32'd7);
    chk("t1_ack", 32'(a), 32'h1);
    chk("t1_result", 32'(r), 32'h18B07);
    chk("t1_err", 32'(e), 32'd0);
    tick();
    chk("t1_busy_fall", 32'(bus.busy), 32'd0);

    // All requests held after reset
    rst = 1'b0; tick(); tick(); rst = 1'b1; tick();
    bus.x_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    bus.req = 4'b1111;
    for (int op = 0; op < 5; op++) begin
      run_op(1 + op, 18'(18'h10000 + op), 0, op == 4, 0, dly, a, r, e);
      gid = -1;
      for (int i = 0; i < N; i++) if (a[i]) gid = i;
      chk("rr_order", 32'(gid), 32'(exp_order[op]));
      chk("rr_result", 32'(r), 32'(18'h10000 + op));
    end
    chk("rr_first_lat", 32'(dly), 32'd7);

    // Stale done during START
    bus.x_in[31:16] = 16'h0777; bus.req = 4'b0010;
    run_op(3, 18'h12345, 1, 1, 0, dly, a, r, e);
    chk("stale_lat", 32'(dly), 32'd5);
    chk("stale_result", 32'(r), 32'h12345);

    // Timeout, then a normal request
    bus.req = 4'b1000;
    run_op(0, 18'h0, 0, 1, 0, dly, a, r, e);
    chk("to_err", 32'(e), 32'd1);
    chk("to_result", 32'(r), 32'd0);
    chk("to_lat", 32'(dly), 32'd10);
    bus.req = 4'b0100;
    run_op(2, 18'h0ABCD, 0, 1, 0, dly, a, r, e);
    chk("after_to_err", 32'(e), 32'd0);
    chk("after_to_ack", 32'(a), 32'h4);
    chk("after_to_result", 32'(r), 32'h0ABCD);

    // Reset pulse in WAIT
    bus.x_in[15:0] = 16'h5555; bus.req = 4'b0001;
    begin
      int n;
      n = 0;
      while (bus.core_start !== 1'b1 && n < 20) begin tick(); n++; end
      chk("rw_start_seen", 32'(bus.core_start), 32'd1);
    end
    tick(); tick();
    #1 rst = 1'b0;
    #1;
    chk("rw_busy", 32'(bus.busy), 32'd0);
    chk("rw_core_x", 32'(bus.core_x), 32'd0);
    chk("rw_ack", 32'(bus.ack), 32'd0);
    chk("rw_core_start", 32'(bus.core_start), 32'd0);
    bus.req = '0;
    tick(); tick();
    rst = 1'b1; bus.req = 4'b0100;
    run_op(1, 18'h1F00D, 0, 1, 0, dly, a, r, e);
    chk("rw_after_ack", 32'(a), 32'h4);

    // Requester drops and operand changes mid-operation
    bus.x_in[15:0] = 16'h1234; bus.req = 4'b0001;
    run_op(3, 18'h2468A, 0, 1, 1, dly, a, r, e);
    chk("drop_ack", 32'(a), 32'h1);
    chk("drop_core_x", 32'(bus.core_x), 32'h1234);

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
